// File: rtl/bindct_pkg.sv
// Shared constants for the 8-point binDCT pipeline: stage count, vector length
// and the mapping from S4 result slots to output coefficient order.
package bindct_pkg;
  localparam int NUM_STAGES = 5;
  localparam int VEC_LEN    = 8;
  // S4 result slots 0..6 hold d0..d6 and slot 7 holds c7; entry i selects Yi.
  localparam int OUT_MAP [VEC_LEN] = '{0, 7, 3, 6, 1, 5, 2, 4};
endpackage

// File: rtl/bindct_lift.sv
// One lifting step: y = (+/-)base (+/-) sum of (src >>> k) for every k set in SHIFT_MASK.
module bindct_lift #(
  parameter int         W          = 32,
  parameter logic [7:0] SHIFT_MASK = 8'h00,
  parameter bit         SUB_SUM    = 1'b0,
  parameter bit         NEG_BASE   = 1'b0
) (
  input  logic signed [W-1:0] base,
  input  logic signed [W-1:0] src,
  output logic signed [W-1:0] y
);
  logic signed [W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int k = 1; k < 8; k++) begin
      if (SHIFT_MASK[k]) sum = sum + (src >>> k);
    end
    y = (NEG_BASE ? -base : base) + (SUB_SUM ? -sum : sum);
  end
endmodule

// File: rtl/bindct8_pipe.sv
// 8-point binDCT, five register stages (butterfly, lift, butterfly, lift, output)
// with a single global stall driven by output back-pressure.
module bindct8_pipe
  import bindct_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int FRAC_BITS = 12,
  parameter int ROUND_OUT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  x_in [VEC_LEN],
  input  logic                        valid_in,
  output logic                        ready_in,
  output logic signed [OUT_WIDTH-1:0] y_out [VEC_LEN],
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic                        busy
);
  typedef logic signed [OUT_WIDTH-1:0] word_t;
  localparam word_t HALF = word_t'(1) <<< (FRAC_BITS - 1);

  logic [NUM_STAGES-1:0] v;
  logic  adv;
  word_t xe [VEC_LEN];
  word_t a_n [VEC_LEN], s1 [VEC_LEN];
  word_t s2_n [VEC_LEN], s2 [VEC_LEN];
  word_t s3_n [VEC_LEN], s3 [VEC_LEN];
  word_t s4_n [VEC_LEN], s4 [VEC_LEN];
  word_t y_n [VEC_LEN];
  word_t b0, b1, d0, d1, d2, d3, d4, d5, d6;

  // Transfers happen on valid && ready; the pipe only freezes while the output is held.
  assign adv       = !(valid_out && !ready_out);
  assign ready_in  = adv;
  assign valid_out = v[NUM_STAGES-1];
  assign busy      = |v;

  // S1: sign-extend, butterfly, scale into fixed point.
  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) xe[i] = word_t'(x_in[i]);
    for (int i = 0; i < 4; i++) begin
      a_n[i]     = (xe[i] + xe[7-i]) <<< FRAC_BITS;
      a_n[4 + i] = (xe[3-i] - xe[4+i]) <<< FRAC_BITS;
    end
  end

  // S2: odd-part lifting; slot 5 becomes b0, slot 6 becomes b1.
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h0C), .SUB_SUM(1'b0), .NEG_BASE(1'b0))
    u_lift_b0 (.base(s1[6]), .src(s1[5]), .y(b0));
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h0A), .SUB_SUM(1'b0), .NEG_BASE(1'b1))
    u_lift_b1 (.base(s1[5]), .src(b0), .y(b1));

  always_comb begin
    s2_n    = s1;
    s2_n[5] = b0;
    s2_n[6] = b1;
  end

  // S3: second butterfly.
  always_comb begin
    s3_n[0] = s2[0] + s2[3];
    s3_n[1] = s2[1] + s2[2];
    s3_n[2] = s2[1] - s2[2];
    s3_n[3] = s2[0] - s2[3];
    s3_n[4] = s2[4] + s2[6];
    s3_n[5] = s2[4] - s2[6];
    s3_n[6] = s2[7] - s2[5];
    s3_n[7] = s2[7] + s2[5];
  end

  // S4: final lifting; d1, d3 and d6 chain off results computed in the same stage.
  assign d0 = s3[0] + s3[1];
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h02), .SUB_SUM(1'b0), .NEG_BASE(1'b1))
    u_lift_d1 (.base(s3[1]), .src(d0), .y(d1));
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h0C), .SUB_SUM(1'b1), .NEG_BASE(1'b0))
    u_lift_d2 (.base(s3[2]), .src(s3[3]), .y(d2));
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h0C), .SUB_SUM(1'b0), .NEG_BASE(1'b0))
    u_lift_d3 (.base(s3[3]), .src(d2), .y(d3));
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h08), .SUB_SUM(1'b1), .NEG_BASE(1'b0))
    u_lift_d4 (.base(s3[4]), .src(s3[7]), .y(d4));
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h0E), .SUB_SUM(1'b0), .NEG_BASE(1'b0))
    u_lift_d5 (.base(s3[5]), .src(s3[6]), .y(d5));
  bindct_lift #(.W(OUT_WIDTH), .SHIFT_MASK(8'h02), .SUB_SUM(1'b1), .NEG_BASE(1'b0))
    u_lift_d6 (.base(s3[6]), .src(d5), .y(d6));

  always_comb begin
    s4_n = '{d0, d1, d2, d3, d4, d5, d6, s3[7]};
  end

  // S5: reorder into coefficient order, optionally round half up to integer.
  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) begin
      if (ROUND_OUT != 0) y_n[i] = (s4[OUT_MAP[i]] + HALF) >>> FRAC_BITS;
      else                y_n[i] = s4[OUT_MAP[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v     <= '0;
      y_out <= '{default: '0};
    end else if (adv) begin
      v <= {v[NUM_STAGES-2:0], valid_in};
      if (valid_in) s1    <= a_n;
      if (v[0])     s2    <= s2_n;
      if (v[1])     s3    <= s3_n;
      if (v[2])     s4    <= s4_n;
      if (v[3])     y_out <= y_n;
    end
  end
endmodule

// File: tb/tb_bindct8_pipe.sv
// Bench for bindct8_pipe: Q-format and rounded instances driven in parallel,
// scored against an arithmetic model of the transform.
module tb_bindct8_pipe;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [7:0]  x_in [8];
  logic               valid_in, ready_out;
  logic               ready_in, valid_out, busy;
  logic signed [31:0] y_out [8];
  logic               ready_in_r, valid_out_r, busy_r;
  logic signed [31:0] y_r [8];

  logic [255:0] exp_q[$];
  logic [255:0] exp_r_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic         prev_stall = 1'b0;
  logic [255:0] prev_y;

  bindct8_pipe #(.IN_WIDTH(8), .OUT_WIDTH(32), .FRAC_BITS(12), .ROUND_OUT(0)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .valid_in(valid_in), .ready_in(ready_in),
    .y_out(y_out), .valid_out(valid_out), .ready_out(ready_out), .busy(busy));

  bindct8_pipe #(.IN_WIDTH(8), .OUT_WIDTH(32), .FRAC_BITS(12), .ROUND_OUT(1)) dut_r (
    .clk(clk), .rst(rst), .x_in(x_in), .valid_in(valid_in), .ready_in(ready_in_r),
    .y_out(y_r), .valid_out(valid_out_r), .ready_out(ready_out), .busy(busy_r));

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack(input logic signed [31:0] y [8]);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = y[i];
    return p;
  endfunction

  function automatic logic [255:0] pack_int(input int y [8]);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = y[i];
    return p;
  endfunction

  // Reference transform in plain integer arithmetic (no overflow for 8-bit inputs).
  function automatic logic [255:0] ref_dct(input logic signed [7:0] x [8], input bit rnd);
    longint a [8];
    longint c [8];
    longint b0, b1, d0, d1, d2, d3, d4, d5, d6;
    longint y [8];
    logic [255:0] p;
    for (int i = 0; i < 4; i++) begin
      a[i]     = (longint'(x[i]) + longint'(x[7-i])) * 4096;
      a[4 + i] = (longint'(x[3-i]) - longint'(x[4+i])) * 4096;
    end
    b0 = a[6] + (a[5] >>> 2) + (a[5] >>> 3);
    b1 = (b0 >>> 1) + (b0 >>> 3) - a[5];
    c[0] = a[0] + a[3]; c[1] = a[1] + a[2]; c[2] = a[1] - a[2]; c[3] = a[0] - a[3];
    c[4] = a[4] + b1;   c[5] = a[4] - b1;   c[6] = a[7] - b0;   c[7] = a[7] + b0;
    d0 = c[0] + c[1];
    d1 = (d0 >>> 1) - c[1];
    d2 = c[2] - ((c[3] >>> 2) + (c[3] >>> 3));
    d3 = c[3] + (d2 >>> 2) + (d2 >>> 3);
    d4 = c[4] - (c[7] >>> 3);
    d5 = c[5] + (c[6] >>> 1) + (c[6] >>> 2) + (c[6] >>> 3);
    d6 = c[6] - (d5 >>> 1);
    y = '{d0, c[7], d3, d6, d1, d5, d2, d4};
    for (int i = 0; i < 8; i++) begin
      if (rnd) y[i] = (y[i] + 2048) >>> 12;
      p[i*32 +: 32] = y[i][31:0];
    end
    return p;
  endfunction

  // Scoreboard: record accepted vectors, compare on each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_r_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("busy", busy, exp_q.size() != 0);
      check("ready_in", ready_in, !(valid_out && !ready_out));
      check("ready_in_r", ready_in_r, !(valid_out_r && !ready_out));
      if (prev_stall) begin
        check("hold_y", pack(y_out), prev_y);
        check("hold_valid", valid_out, 1'b1);
      end
      prev_stall = valid_out && !ready_out;
      prev_y     = pack(y_out);
      if (valid_out && ready_out) begin
        check("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("y_q", pack(y_out), exp_q.pop_front());
          check("valid_r", valid_out_r, 1'b1);
          check("y_rnd", pack(y_r), exp_r_q.pop_front());
        end
      end
      if (valid_in && ready_in) begin
        exp_q.push_back(ref_dct(x_in, 1'b0));
        exp_r_q.push_back(ref_dct(x_in, 1'b1));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in  = 1'b0;
      ready_out = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    for (int i = 0; i < n; i++) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One isolated vector: checks latency and the coefficients against constants.
  task automatic run_one(input int xv [8], input int e0 [8], input int e1 [8]);
    int lat;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) x_in[i] = 8'(xv[i]);
    valid_in = 1'b1; ready_out = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 5);
    check("const_y_q", pack(y_out), pack_int(e0));
    check("const_y_rnd", pack(y_r), pack_int(e1));
    idle(2);
  endtask

  // Back-to-back stream with ready_out low during cycles [st_lo, st_hi].
  task automatic burst(input int n, input int st_lo, input int st_hi, input bit alt);
    int sent = 0;
    int cyc  = 0;
    bit acc  = 1'b1;
    while (sent < n && cyc < 200) begin
      @(posedge clk); #1;
      ready_out = !(cyc >= st_lo && cyc <= st_hi);
      if (acc) begin
        for (int i = 0; i < 8; i++)
          x_in[i] = alt ? (((i + sent) % 2 == 1) ? -8'sd128 : 8'sd127) : 8'($urandom_range(0, 255));
      end
      valid_in = 1'b1;
      @(negedge clk);
      if (cyc >= st_lo && cyc <= st_hi) check("stall_ready_in", ready_in, 1'b0);
      acc = ready_in;
      if (acc) sent++;
      cyc++;
    end
    check("burst_sent", sent, n);
    @(posedge clk); #1;
    valid_in = 1'b0; ready_out = 1'b1;
  endtask

  task automatic drain();
    int cyc = 0;
    valid_in = 1'b0; ready_out = 1'b1;
    while ((exp_q.size() != 0 || busy) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    rst = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    for (int i = 0; i < 8; i++) x_in[i] = '0;

    // Reset state
    do_reset(3);
    @(negedge clk);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready_in", ready_in, 1'b1);
    check("rst_y_out", pack(y_out), '0);

    // DC input and single impulse
    run_one('{1, 1, 1, 1, 1, 1, 1, 1}, '{32768, 0, 0, 0, 0, 0, 0, 0}, '{8, 0, 0, 0, 0, 0, 0, 0});
    run_one('{1, 0, 0, 0, 0, 0, 0, 0},
            '{4096, 4096, 3520, 2304, 2048, 3584, -1536, -512},
            '{1, 1, 1, 1, 1, 1, 0, 0});

    // Back-pressure while streaming
    burst(10, 7, 9, 1'b0);
    drain();

    // Extreme alternating inputs
    burst(6, 100, 100, 1'b1);
    drain();

    // Reset with vectors in flight
    burst(3, 100, 100, 1'b0);
    idle(1);
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("flush_valid_out", valid_out, 1'b0);
      check("flush_busy", busy, 1'b0);
    end

    // Random traffic with random back-pressure
    acc = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      ready_out = ($urandom_range(0, 9) < 7);
      if (acc || !valid_in) begin
        valid_in = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < 8; i++) x_in[i] = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      acc = valid_in && ready_in;
    end
    @(posedge clk); #1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bindct8_pipe.md
BINDCT8_PIPE -- requirements
Module: bindct8_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, signed input sample width.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, signed internal and output datapath width.
REQ-003 SHALL have parameter FRAC_BITS, default 12, fixed-point fraction bits added at entry.
REQ-004 SHALL have parameter ROUND_OUT, default 0; 0 = outputs in Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS, 1 = outputs rounded to integer.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port x_in  input  signed [IN_WIDTH-1:0] x8  input vector x0..x7.
REQ-008 SHALL have port valid_in  input  1  x_in valid.
REQ-009 SHALL have port ready_in  output  1  block accepts x_in this cycle.
REQ-010 SHALL have port y_out  output  signed [OUT_WIDTH-1:0] x8  DCT coefficients Y0..Y7.
REQ-011 SHALL have port valid_out  output  1  y_out valid.
REQ-012 SHALL have port ready_out  input  1  downstream accepts y_out.
REQ-013 SHALL have port busy  output  1  any pipeline stage holds a valid vector.

Function
REQ-014 SHALL be a 5-stage pipeline: S1 entry butterfly, S2 odd lifting, S3 second butterfly, S4 final lifting, S5 output register; one vector per cycle when not stalled.
REQ-015 SHALL have latency exactly 5 cycles from accept (valid_in && ready_in) to valid_out, absent stalls.
REQ-016 SHALL stall all stages together when valid_out && !ready_out; ready_in = !(valid_out && !ready_out), combinational.
REQ-017 SHALL hold y_out and valid_out stable while stalled; no vector dropped or duplicated.
REQ-018 SHALL propagate bubbles: a stage's valid bit SHALL be cleared when its upstream is empty and the pipe advances.
REQ-019 S1: inputs sign-extended to OUT_WIDTH, then a0..a3 = (x0+x7, x1+x6, x2+x5, x3+x4) << FRAC_BITS, a4..a7 = (x3-x4, x2-x5, x1-x6, x0-x7) << FRAC_BITS.
REQ-020 S2: b0 = a6 + (a5>>>2) + (a5>>>3); b1 = (b0>>>1) + (b0>>>3) - a5; all shifts arithmetic; a0..a4, a7 carried forward.
REQ-021 S3: c0=a0+a3, c1=a1+a2, c2=a1-a2, c3=a0-a3, c4=a4+b1, c5=a4-b1, c6=a7-b0, c7=a7+b0.
REQ-022 S4: d0=c0+c1; d1=(d0>>>1)-c1; d2=c2-((c3>>>2)+(c3>>>3)); d3=c3+(d2>>>2)+(d2>>>3); d4=c4-(c7>>>3); d5=c5+(c6>>>1)+(c6>>>2)+(c6>>>3); d6=c6-(d5>>>1); c7 carried forward.
REQ-023 Output order: Y0=d0, Y1=c7, Y2=d3, Y3=d6, Y4=d1, Y5=d5, Y6=d2, Y7=d4; all eight SHALL come from the same input vector in the same cycle.
REQ-024 ROUND_OUT=1: S5 SHALL register (d + 2^(FRAC_BITS-1)) >>> FRAC_BITS per coefficient (round half up).
REQ-025 Arithmetic SHALL wrap at OUT_WIDTH (two's complement); no saturation.
REQ-026 busy SHALL be OR of all stage valid bits.

Reset
REQ-027 While rst=0 at a clock edge: all stage valid bits, valid_out, busy SHALL go 0; y_out SHALL be 0; ready_in SHALL be 1 after release.
REQ-028 Reset mid-operation SHALL discard all in-flight vectors; no valid_out for them after release.

Structure
REQ-029 Shared package bindct_pkg SHALL hold stage count (5), vector length (8), and output index map constant.
REQ-030 Lifting step (x + sum of x>>>k terms) SHALL be a sub-module bindct_lift, instanced per lift.

Verification
REQ-031 x = all 1, ROUND_OUT=0, ready_out=1 -> 5 cycles later Y0=32768, Y1..Y7=0.
REQ-032 x0=1, others 0, ROUND_OUT=0 -> Y=[4096,4096,3520,2304,2048,3584,-1536,-512].
REQ-033 Same impulse, ROUND_OUT=1 -> Y=[1,1,1,1,1,1,0,0].
REQ-034 10 back-to-back vectors, ready_out=0 for cycles 7-9 -> ready_in low those cycles, all 10 outputs correct, in order, none lost.
REQ-035 Reset asserted 2 cycles after 3 accepts -> valid_out stays 0, busy 0 after release.
REQ-036 x = +127/-128 alternating, IN_WIDTH=8 -> results match bit-exact reference model, no overflow at OUT_WIDTH=32.
